// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode/state encodings and default widths for the LED sequencer.
package led_seq_pkg;
    localparam int DEF_PRESCALE = 4;
    localparam int DEF_PAT_W    = 8;
    localparam int DEF_REP_W    = 4;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_PATTERN = 2'b10,
        MODE_PWM     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ON   = 2'b01,
        S_PAT  = 2'b10,
        S_PWM  = 2'b11
    } state_e;

    function automatic state_e mode_to_state(input mode_e m);
        return (m == MODE_ON)      ? S_ON  :
               (m == MODE_PATTERN) ? S_PAT :
               (m == MODE_PWM)     ? S_PWM : S_IDLE;
    endfunction
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: PRESCALE-clock tick generator.
//   clk  - clock          rst  - async active-low reset
//   clr  - sync clear     tick - high one cycle in every PRESCALE
module led_tick_gen #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt_q, cnt_d;

    // After a clear the first tick lands PRESCALE edges later.
    always_comb tick = cnt_q == 8'(PRESCALE - 1);
    always_comb cnt_d = (clr || tick) ? 8'd0 : cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= 8'd0;
        else      cnt_q <= cnt_d;
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: drives the LED from OFF/ON/PATTERN/PWM commands.
//   clk, rst (async active-low)
//   cmd_valid/cmd_ready handshake; cmd_mode, cmd_data (pattern or duty), cmd_repeat (0 = forever)
//   led  - registered drive;  busy - not IDLE;  done - one-cycle pulse at finite pattern end
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int PAT_W    = DEF_PAT_W,
    parameter int REP_W    = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [PAT_W-1:0] cmd_data,
    input  logic [REP_W-1:0] cmd_repeat,
    output logic             led,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   data_q, data_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [PAT_W-1:0]   pc_q, pc_d;
    logic               led_q, led_d;
    logic               done_q, done_d;
    logic               accept, tick;

    // Only a finite pattern blocks new commands.
    always_comb cmd_ready = (state_q != S_PAT) || (rep_q == '0);
    always_comb accept = cmd_valid && cmd_ready;

    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rep_d   = rep_q;
        idx_d   = idx_q;
        pc_d    = pc_q + 1'b1;
        done_d  = 1'b0;
        if (accept) begin
            state_d = mode_to_state(mode_e'(cmd_mode));
            data_d  = cmd_data;
            rep_d   = cmd_repeat;
            idx_d   = '0;
            pc_d    = '0;
        end else if (state_q == S_PAT && tick) begin
            if (idx_q == IDX_W'(PAT_W - 1)) begin
                idx_d = '0;
                if (rep_q != '0) rep_d = rep_q - 1'b1;
                if (rep_q == REP_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        // The LED register is loaded from next-state values so it changes on the same edge.
        led_d = (state_d == S_ON)  ? 1'b1 :
                (state_d == S_PAT) ? data_d[idx_d] :
                (state_d == S_PWM) ? (pc_d < data_d) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            rep_q   <= '0;
            idx_q   <= '0;
            pc_q    <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rep_q   <= rep_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end

    always_comb begin
        led  = led_q;
        done = done_q;
        busy = state_q != S_IDLE;
    end
endmodule
